// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake between the program sequencer and the ALU issue controller.
interface alu_issue_ctrl_if #(
    parameter int INSTR_WIDTH = 24
);
    logic [INSTR_WIDTH-1:0] ps_instr;
    logic                   ps_instr_vld;
    logic                   ps_instr_rdy;

    modport master (
        output ps_instr,
        output ps_instr_vld,
        input  ps_instr_rdy
    );

    modport slave (
        input  ps_instr,
        input  ps_instr_vld,
        output ps_instr_rdy
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded ALU instruction at a time, evaluates its condition code and
// captures the returned ALU flags into ASTAT / STKY.
module alu_issue_ctrl #(
    parameter int INSTR_WIDTH = 24,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_issue_ctrl_if.slave       ps_if,
    input  logic                  mode_sat,
    input  logic                  stky_clr,
    input  logic                  alu_ps_az,
    input  logic                  alu_ps_an,
    input  logic                  alu_ps_ac,
    input  logic                  alu_ps_av,
    output logic                  ps_alu_en,
    output logic                  ps_alu_log,
    output logic [1:0]            ps_alu_hc,
    output logic [2:0]            ps_alu_sc,
    output logic                  ps_alu_sat,
    output logic [ADDR_WIDTH-1:0] xb_rx_addr,
    output logic [ADDR_WIDTH-1:0] xb_ry_addr,
    output logic                  rf_wr_en,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [3:0]            astat,
    output logic [1:0]            stky,
    output logic                  instr_done,
    output logic                  instr_skip,
    output logic                  instr_illegal
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, EXEC = 2'd2} state_t;

    state_t                state_q;
    logic                  rdy_q, en_q, log_q, sat_q, wr_en_q;
    logic [1:0]            hc_q;
    logic [2:0]            sc_q;
    logic [ADDR_WIDTH-1:0] rx_q, ry_q, wr_addr_q;
    logic [3:0]            astat_q, astat_d;
    logic [1:0]            stky_q, stky_d;
    logic                  done_q, skip_q, ill_q;

    logic                  accept_s, legal_s, cond_ok_s, av_set_s, is_cmp_s;
    logic                  f_log_s;
    logic [1:0]            f_hc_s;
    logic [2:0]            f_sc_s;
    logic [3:0]            f_cond_s;
    logic [ADDR_WIDTH-1:0] f_rn_s, f_rx_s, f_ry_s;
    logic                  unused_bits_s;

    function automatic logic op_legal(input logic lg, input logic [1:0] hc, input logic [2:0] sc);
        logic ok;
        case ({lg, hc, sc})
            6'b1_00_000, 6'b1_00_001, 6'b1_00_010,
            6'b1_10_000, 6'b1_10_001, 6'b1_11_000,
            6'b0_00_000, 6'b0_00_001, 6'b0_00_010, 6'b0_00_011, 6'b0_00_101,
            6'b0_01_001, 6'b0_01_011, 6'b0_10_001, 6'b0_11_001: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // astat layout is {av, ac, an, az}
    function automatic logic cond_true(input logic [3:0] cnd, input logic [3:0] st);
        logic t;
        case (cnd)
            4'b0000: t = 1'b1;
            4'b0001: t = st[0];
            4'b0010: t = ~st[0];
            4'b0011: t = st[1];
            4'b0100: t = ~st[1];
            4'b0101: t = st[2];
            4'b0110: t = ~st[2];
            4'b0111: t = st[3];
            4'b1000: t = ~st[3];
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    assign f_log_s       = ps_if.ps_instr[22];
    assign f_hc_s        = ps_if.ps_instr[21:20];
    assign f_sc_s        = ps_if.ps_instr[19:17];
    assign f_cond_s      = ps_if.ps_instr[16:13];
    assign f_rn_s        = ps_if.ps_instr[12:9];
    assign f_rx_s        = ps_if.ps_instr[8:5];
    assign f_ry_s        = ps_if.ps_instr[4:1];
    assign unused_bits_s = ps_if.ps_instr[23] ^ ps_if.ps_instr[0];

    // Accept decode, flag capture and sticky next-state
    always_comb begin
        accept_s  = (state_q == IDLE) && rdy_q && ps_if.ps_instr_vld;
        legal_s   = op_legal(f_log_s, f_hc_s, f_sc_s);
        cond_ok_s = cond_true(f_cond_s, astat_q);
        is_cmp_s  = !log_q && (hc_q == 2'b00) && (sc_q == 3'b101);
        astat_d   = astat_q;
        av_set_s  = 1'b0;
        if (state_q == EXEC) begin
            if (log_q) begin
                astat_d = {2'b00, alu_ps_an, alu_ps_az};
            end else if (is_cmp_s) begin
                astat_d = {astat_q[3:2], alu_ps_an, alu_ps_az};
            end else begin
                astat_d  = {alu_ps_av, alu_ps_ac, alu_ps_an, alu_ps_az};
                av_set_s = alu_ps_av;
            end
        end else begin
            astat_d = astat_q;
        end
        // a set event in the same cycle as stky_clr takes priority
        stky_d[1] = (stky_q[1] & ~stky_clr) | (accept_s & ~legal_s);
        stky_d[0] = (stky_q[0] & ~stky_clr) | av_set_s;
    end

    // Issue sequencer with registered control and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rdy_q     <= 1'b0;
            en_q      <= 1'b0;
            log_q     <= 1'b0;
            hc_q      <= 2'b00;
            sc_q      <= 3'b000;
            sat_q     <= 1'b0;
            rx_q      <= '0;
            ry_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            astat_q   <= 4'b0000;
            stky_q    <= 2'b00;
            done_q    <= 1'b0;
            skip_q    <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            en_q    <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            skip_q  <= 1'b0;
            ill_q   <= 1'b0;
            astat_q <= astat_d;
            stky_q  <= stky_d;
            case (state_q)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (accept_s) begin
                        if (!legal_s) begin
                            ill_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else if (!cond_ok_s) begin
                            skip_q <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            state_q   <= ISSUE;
                            rdy_q     <= 1'b0;
                            en_q      <= 1'b1;
                            log_q     <= f_log_s;
                            hc_q      <= f_hc_s;
                            sc_q      <= f_sc_s;
                            sat_q     <= mode_sat;
                            rx_q      <= f_rx_s;
                            ry_q      <= f_ry_s;
                            wr_addr_q <= f_rn_s;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= EXEC;
                    rdy_q   <= 1'b0;
                    wr_en_q <= ~is_cmp_s;
                end
                EXEC: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign ps_if.ps_instr_rdy = rdy_q;
    assign ps_alu_en          = en_q;
    assign ps_alu_log         = log_q;
    assign ps_alu_hc          = hc_q;
    assign ps_alu_sc          = sc_q;
    assign ps_alu_sat         = sat_q;
    assign xb_rx_addr         = rx_q;
    assign xb_ry_addr         = ry_q;
    assign rf_wr_en           = wr_en_q;
    assign rf_wr_addr         = wr_addr_q;
    assign astat              = astat_q;
    assign stky               = stky_q;
    assign instr_done         = done_q;
    assign instr_skip         = skip_q;
    assign instr_illegal      = ill_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; retirement results are checked from a scoreboard queue.
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       mode_sat, stky_clr;
    logic       alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av;
    logic       ps_alu_en, ps_alu_log, ps_alu_sat, rf_wr_en;
    logic [1:0] ps_alu_hc;
    logic [2:0] ps_alu_sc;
    logic [3:0] xb_rx_addr, xb_ry_addr, rf_wr_addr;
    logic [3:0] astat;
    logic [1:0] stky;
    logic       instr_done, instr_skip, instr_illegal;

    int checks = 0;
    int errors = 0;

    // kind: 0 retired, 1 skipped, 2 illegal
    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] astat;
        logic [1:0] stky;
    } exp_t;
    exp_t sb_q[$];

    alu_issue_ctrl_if #(.INSTR_WIDTH(24)) ps_if();

    alu_issue_ctrl #(.INSTR_WIDTH(24), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .ps_if(ps_if),
        .mode_sat(mode_sat), .stky_clr(stky_clr),
        .alu_ps_az(alu_ps_az), .alu_ps_an(alu_ps_an), .alu_ps_ac(alu_ps_ac), .alu_ps_av(alu_ps_av),
        .ps_alu_en(ps_alu_en), .ps_alu_log(ps_alu_log), .ps_alu_hc(ps_alu_hc), .ps_alu_sc(ps_alu_sc),
        .ps_alu_sat(ps_alu_sat), .xb_rx_addr(xb_rx_addr), .xb_ry_addr(xb_ry_addr),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .astat(astat), .stky(stky),
        .instr_done(instr_done), .instr_skip(instr_skip), .instr_illegal(instr_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] mk(input logic lg, input logic [1:0] hc, input logic [2:0] sc,
                                       input logic [3:0] cnd, input logic [3:0] rn,
                                       input logic [3:0] rx, input logic [3:0] ry);
        return {1'b0, lg, hc, sc, cnd, rn, rx, ry, 1'b0};
    endfunction

    task automatic set_flags(input logic z, input logic n, input logic c, input logic v);
        alu_ps_az = z; alu_ps_an = n; alu_ps_ac = c; alu_ps_av = v;
    endtask

    // Called at a negedge; returns at the negedge of the cycle after accept.
    task automatic send(input logic [23:0] w, input logic sat, input exp_t e, input logic track);
        chk("rdy_before_send", {7'd0, ps_if.ps_instr_rdy}, 8'd1);
        if (track) sb_q.push_back(e);
        ps_if.ps_instr     = w;
        ps_if.ps_instr_vld = 1'b1;
        mode_sat           = sat;
        @(negedge clk);
        ps_if.ps_instr_vld = 1'b0;
        mode_sat           = 1'b0;
    endtask

    task automatic wait_done();
        exp_t e;
        bit   seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (instr_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_timeout", {7'd0, seen}, 8'd1);
        if (sb_q.size() == 0) begin
            chk("sb_empty_on_done", 8'd1, {7'd0, seen ^ 1'b1});
        end else begin
            e = sb_q.pop_front();
            chk("done_skip",    {7'd0, instr_skip},    {7'd0, e.kind == 2'd1});
            chk("done_illegal", {7'd0, instr_illegal}, {7'd0, e.kind == 2'd2});
            chk("done_astat",   {4'd0, astat}, {4'd0, e.astat});
            chk("done_stky",    {6'd0, stky},  {6'd0, e.stky});
        end
    endtask

    initial begin
        bit saw_done;
        reset = 1'b1;
        ps_if.ps_instr = 24'd0; ps_if.ps_instr_vld = 1'b0;
        mode_sat = 1'b0; stky_clr = 1'b0;
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        chk("rst_en",    {7'd0, ps_alu_en}, 8'd0);
        chk("rst_wr_en", {7'd0, rf_wr_en},  8'd0);
        chk("rst_astat", {4'd0, astat}, 8'd0);
        chk("rst_stky",  {6'd0, stky},  8'd0);
        chk("rst_done",  {7'd0, instr_done}, 8'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk("rdy_after_reset", {7'd0, ps_if.ps_instr_rdy}, 8'd1);

        // ADD Rn=3, Rx=1, Ry=2: flags az0 an1 ac0 av1
        set_flags(1'b0, 1'b1, 1'b0, 1'b1);
        send(mk(1'b0, 2'b00, 3'b000, 4'b0000, 4'd3, 4'd1, 4'd2), 1'b0, '{2'd0, 4'b1010, 2'b01}, 1'b1);
        chk("add_en_c1",  {7'd0, ps_alu_en}, 8'd1);
        chk("add_rx_c1",  {4'd0, xb_rx_addr}, 8'd1);
        chk("add_ry_c1",  {4'd0, xb_ry_addr}, 8'd2);
        chk("add_rdy_c1", {7'd0, ps_if.ps_instr_rdy}, 8'd0);
        @(negedge clk);
        chk("add_en_c2",    {7'd0, ps_alu_en}, 8'd0);
        chk("add_wr_en_c2", {7'd0, rf_wr_en},  8'd1);
        chk("add_wr_addr",  {4'd0, rf_wr_addr}, 8'd3);
        wait_done();
        chk("add_rdy_c3", {7'd0, ps_if.ps_instr_rdy}, 8'd1);

        // ADD producing astat=0110, then clear sticky
        set_flags(1'b0, 1'b1, 1'b1, 1'b0);
        send(mk(1'b0, 2'b00, 3'b001, 4'b0000, 4'd4, 4'd5, 4'd6), 1'b0, '{2'd0, 4'b0110, 2'b01}, 1'b1);
        wait_done();
        stky_clr = 1'b1;
        @(negedge clk);
        stky_clr = 1'b0;
        chk("stky_clr", {6'd0, stky}, 8'd0);

        // Compare: only az/an captured, av not captured so avs stays clear
        set_flags(1'b1, 1'b0, 1'b0, 1'b1);
        send(mk(1'b0, 2'b00, 3'b101, 4'b0000, 4'd7, 4'd1, 4'd2), 1'b0, '{2'd0, 4'b0101, 2'b00}, 1'b1);
        @(negedge clk);
        chk("cmp_no_wr", {7'd0, rf_wr_en}, 8'd0);
        wait_done();

        // Logic op clears ac/av: astat -> 0000
        set_flags(1'b0, 1'b0, 1'b1, 1'b1);
        send(mk(1'b1, 2'b00, 3'b000, 4'b0000, 4'd2, 4'd3, 4'd4), 1'b0, '{2'd0, 4'b0000, 2'b00}, 1'b1);
        @(negedge clk);
        chk("log_wr_en", {7'd0, rf_wr_en}, 8'd1);
        wait_done();

        // cond=0001 with az=0 -> skip
        send(mk(1'b0, 2'b00, 3'b000, 4'b0001, 4'd1, 4'd1, 4'd1), 1'b0, '{2'd1, 4'b0000, 2'b00}, 1'b1);
        chk("skip_en",  {7'd0, ps_alu_en}, 8'd0);
        chk("skip_rdy", {7'd0, ps_if.ps_instr_rdy}, 8'd1);
        wait_done();
        @(negedge clk);
        chk("skip_en_later", {7'd0, ps_alu_en}, 8'd0);

        // cond=1010 is never true
        send(mk(1'b0, 2'b00, 3'b000, 4'b1010, 4'd1, 4'd1, 4'd1), 1'b0, '{2'd1, 4'b0000, 2'b00}, 1'b1);
        wait_done();

        // Illegal log=1 hc01
        send(mk(1'b1, 2'b01, 3'b000, 4'b0000, 4'd1, 4'd1, 4'd1), 1'b0, '{2'd2, 4'b0000, 2'b10}, 1'b1);
        chk("ill_en", {7'd0, ps_alu_en}, 8'd0);
        wait_done();

        // Saturation latched at accept; stky_clr coincident with av set
        set_flags(1'b0, 1'b0, 1'b1, 1'b1);
        send(mk(1'b0, 2'b01, 3'b001, 4'b0000, 4'd9, 4'd8, 4'd7), 1'b1, '{2'd0, 4'b1100, 2'b01}, 1'b1);
        chk("sat_issue", {7'd0, ps_alu_sat}, 8'd1);
        chk("sat_hc",    {6'd0, ps_alu_hc}, 8'd1);
        @(negedge clk);
        chk("sat_exec",  {7'd0, ps_alu_sat}, 8'd1);
        stky_clr = 1'b1;
        @(negedge clk);
        stky_clr = 1'b0;
        wait_done();

        // Reset during EXEC of ADD Rn=3
        set_flags(1'b1, 1'b1, 1'b1, 1'b1);
        send(mk(1'b0, 2'b00, 3'b000, 4'b0000, 4'd3, 4'd1, 4'd2), 1'b0, '{2'd0, 4'b0000, 2'b00}, 1'b0);
        @(negedge clk);
        chk("pre_rst_wr_en", {7'd0, rf_wr_en}, 8'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_wr_en", {7'd0, rf_wr_en}, 8'd0);
        chk("mid_rst_astat", {4'd0, astat}, 8'd0);
        chk("mid_rst_stky",  {6'd0, stky},  8'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_rdy", {7'd0, ps_if.ps_instr_rdy}, 8'd1);
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (instr_done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        chk("mid_rst_no_done", {7'd0, saw_done}, 8'd0);
        chk("sb_drained", sb_q.size()[7:0], 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
